pwm_accumulate: RTL

//  Downstream stage of the point-wise multiplier (PWM) compute stage. It consumes the product

---
 rtl/pwm_accumulate_pkg.sv | 24 ++
 rtl/pwm_accumulate_if.sv | 30 +++
 rtl/pwm_mod_add.sv | 28 ++
 rtl/pwm_accumulate.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_accumulate_pkg.sv
// Shared definitions for the PWM accumulate stage: modulus, widths, FSM state type and the
// 64-bit two-coefficient beat packing used on both the product input and the result output.
package pwm_accumulate_pkg;

  localparam int unsigned Q      = 8380417;
  localparam int unsigned COEF_W = 23;
  localparam int unsigned NWORDS = 128;
  localparam int unsigned AddrW  = 7;

  typedef logic [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StFlush,
    StDrain
  } state_e;

  // {9'd0, hi, 9'd0, lo}
  function automatic logic [63:0] pack_beat(coef_t lo, coef_t hi);
    return {9'd0, hi, 9'd0, lo};
  endfunction

endpackage

// File: rtl/pwm_accumulate_if.sv
// Control and stream signals of the PWM accumulate stage.
//   acc_start/column_length/acc_done : accumulation control
//   s_tvalid/s_tdata/s_tready        : product beat input stream
//   m_tvalid/m_tdata/m_tready        : result beat output stream
// master = driver side (upstream/downstream environment), slave = the accumulate stage.
interface pwm_accumulate_if;

  logic        acc_start;
  logic [3:0]  column_length;
  logic        acc_done;

  logic        s_tvalid;
  logic [63:0] s_tdata;
  logic        s_tready;

  logic        m_tvalid;
  logic [63:0] m_tdata;
  logic        m_tready;

  modport master (
    output acc_start, column_length, s_tvalid, s_tdata, m_tready,
    input  acc_done, s_tready, m_tvalid, m_tdata
  );

  modport slave (
    input  acc_start, column_length, s_tvalid, s_tdata, m_tready,
    output acc_done, s_tready, m_tvalid, m_tdata
  );

endinterface

// File: rtl/pwm_mod_add.sv
// Single-lane combinational modular adder: y = (a + b) mod Q for a, b < Q.
//   a_i, b_i : addends, each < Q
//   y_o      : sum reduced into [0, Q)
module pwm_mod_add
  import pwm_accumulate_pkg::*;
(
  input  coef_t a_i,
  input  coef_t b_i,
  output coef_t y_o
);

  localparam logic [COEF_W:0] QWide = (COEF_W + 1)'(Q);

  logic [COEF_W:0] sum;
  logic [COEF_W:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = sum - QWide;

  // Inputs below Q keep the sum below 2Q, so one conditional subtract suffices.
  always_comb begin
    y_o = sum[COEF_W-1:0];
    if (sum >= QWide) begin
      y_o = diff[COEF_W-1:0];
    end
  end

endmodule

// File: rtl/pwm_accumulate.sv
// Sums column_length product polynomials coefficient-wise mod Q into a 128x46 buffer, then
// streams the 128 result beats out.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of pwm_accumulate_if (control, product input, result output)
module pwm_accumulate
  import pwm_accumulate_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  pwm_accumulate_if.slave    bus
);

  state_e             state_q;
  logic [AddrW-1:0]   w_q;
  logic [3:0]         c_q, len_q;
  logic               flush_q;
  logic               acc_done_q;

  // Accumulate pipeline: stage 1 waits for the RAM read, stage 2 holds the sum being written.
  logic               v1_q, first1_q;
  logic [AddrW-1:0]   a1_q;
  coef_t              lo1_q, hi1_q;
  logic               v2_q;
  logic [AddrW-1:0]   a2_q;
  logic [2*COEF_W-1:0] sum2_q;

  // Drain side: read pointer, one-cycle read in flight, 2-entry skid with head in sk0_q.
  logic [AddrW:0]     rd_addr_q;
  logic               inflight_q;
  logic [1:0]         cnt_q;
  logic [2*COEF_W-1:0] sk0_q, sk1_q;
  logic [AddrW-1:0]   po_q;

  logic [2*COEF_W-1:0] mem [NWORDS];
  logic [2*COEF_W-1:0] rdata_q;
  logic [AddrW-1:0]   raddr;

  logic               accept, pop, issue;
  logic [2:0]         occ;
  coef_t              add_lo, add_hi;
  logic [2*COEF_W-1:0] sum_d;
  logic               unused_bits;

  assign unused_bits = ^{bus.s_tdata[63:55], bus.s_tdata[31:23]};

  assign accept = (state_q == StAccum) && bus.s_tvalid;
  assign pop    = (cnt_q != 2'd0) && bus.m_tready;
  assign occ    = {1'b0, cnt_q} + {2'b0, inflight_q};
  // Only issue a read if the skid can still hold it once it returns next cycle.
  assign issue  = (state_q == StDrain) && !rd_addr_q[AddrW] && (occ < 3'd2 + {2'b0, pop});
  assign raddr  = (state_q == StDrain) ? rd_addr_q[AddrW-1:0] : w_q;

  pwm_mod_add u_add_lo (
    .a_i (rdata_q[COEF_W-1:0]),
    .b_i (lo1_q),
    .y_o (add_lo)
  );

  pwm_mod_add u_add_hi (
    .a_i (rdata_q[2*COEF_W-1:COEF_W]),
    .b_i (hi1_q),
    .y_o (add_hi)
  );

  // Column 0 overwrites whatever the buffer held, so no clear pass is needed.
  assign sum_d = first1_q ? {hi1_q, lo1_q} : {add_hi, add_lo};

  assign bus.s_tready = (state_q == StAccum);
  assign bus.m_tvalid = (cnt_q != 2'd0);
  assign bus.m_tdata  = pack_beat(sk0_q[COEF_W-1:0], sk0_q[2*COEF_W-1:COEF_W]);
  assign bus.acc_done = acc_done_q;

  always_ff @(posedge clk) begin
    if (v2_q) begin
      mem[a2_q] <= sum2_q;
    end
    rdata_q <= mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      w_q        <= '0;
      c_q        <= '0;
      len_q      <= '0;
      flush_q    <= 1'b0;
      acc_done_q <= 1'b0;
      v1_q       <= 1'b0;
      first1_q   <= 1'b0;
      a1_q       <= '0;
      lo1_q      <= '0;
      hi1_q      <= '0;
      v2_q       <= 1'b0;
      a2_q       <= '0;
      sum2_q     <= '0;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      sk0_q      <= '0;
      sk1_q      <= '0;
      po_q       <= '0;
    end else begin
      acc_done_q <= 1'b0;

      v1_q <= accept;
      if (accept) begin
        a1_q     <= w_q;
        first1_q <= (c_q == 4'd0);
        lo1_q    <= bus.s_tdata[COEF_W-1:0];
        hi1_q    <= bus.s_tdata[32+COEF_W-1:32];
      end
      v2_q <= v1_q;
      if (v1_q) begin
        a2_q   <= a1_q;
        sum2_q <= sum_d;
      end

      inflight_q <= issue;
      if (issue) begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end

      if (inflight_q && pop) begin
        if (cnt_q == 2'd2) begin
          sk0_q <= sk1_q;
          sk1_q <= rdata_q;
        end else begin
          sk0_q <= rdata_q;
        end
      end else if (pop) begin
        sk0_q <= sk1_q;
        cnt_q <= cnt_q - 2'd1;
      end else if (inflight_q) begin
        if (cnt_q == 2'd0) begin
          sk0_q <= rdata_q;
        end else begin
          sk1_q <= rdata_q;
        end
        cnt_q <= cnt_q + 2'd1;
      end
      if (pop) begin
        po_q <= po_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.acc_start) begin
            if (bus.column_length == 4'd0) begin
              acc_done_q <= 1'b1;
            end else begin
              len_q   <= bus.column_length;
              w_q     <= '0;
              c_q     <= '0;
              state_q <= StAccum;
            end
          end
        end
        StAccum: begin
          if (accept) begin
            w_q <= w_q + 1'b1;
            if (w_q == AddrW'(NWORDS - 1)) begin
              c_q <= c_q + 4'd1;
              if (c_q == len_q - 4'd1) begin
                flush_q <= 1'b0;
                state_q <= StFlush;
              end
            end
          end
        end
        StFlush: begin
          // Two cycles lets the last sum reach the buffer before the first drain read.
          if (flush_q) begin
            state_q <= StDrain;
          end else begin
            flush_q <= 1'b1;
          end
        end
        StDrain: begin
          if (pop && (po_q == AddrW'(NWORDS - 1))) begin
            acc_done_q <= 1'b1;
            rd_addr_q  <= '0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
